// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU instruction sequencer.
// ALU codes, instruction field positions, op constants, FSM states.
package alu_seq_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int FLAG_W     = 5;
  localparam int INSTR_W    = 16;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_CMP  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_MOV  = 5'd6;
  localparam logic [4:0] ALU_LSH  = 5'd7;
  localparam logic [4:0] ALU_RSH  = 5'd8;
  localparam logic [4:0] ALU_ARSH = 5'd9;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 8;
  localparam int FN_HI   = 7;
  localparam int FN_LO   = 4;
  localparam int RS_HI   = 3;
  localparam int RS_LO   = 0;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_IMAX  = 4'hA;
  localparam logic [3:0] OP_NOP   = 4'hF;
  localparam logic [3:0] FN_MAX   = 4'h9;

  localparam logic [INSTR_W-1:0] INSTR_NOP = 16'hF000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Logical and shift ops take an unsigned immediate.
  function automatic logic imm_zext(input logic [4:0] c);
    return (c == ALU_AND) || (c == ALU_OR)  ||
           (c == ALU_XOR) || (c == ALU_LSH) ||
           (c == ALU_RSH) || (c == ALU_ARSH);
  endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational instruction decoder.
// Splits a 16-bit word into datapath controls plus legality.
module alu_instr_decode
  import alu_seq_pkg::*;
(
  input  logic [INSTR_W-1:0]    i_instr,
  output logic [REG_ADDR_W-1:0] o_rdest,
  output logic [REG_ADDR_W-1:0] o_rsrc,
  output logic [4:0]            o_opcode,
  output logic [DATA_W-1:0]     o_imm,
  output logic                  o_imm_s,
  output logic                  o_wr_en,
  output logic                  o_legal,
  output logic                  o_is_nop
);

  logic [3:0] w_op;
  logic [3:0] w_fn;
  logic [7:0] w_imm8;
  logic [4:0] w_icode;

  assign w_op    = i_instr[OP_HI:OP_LO];
  assign w_fn    = i_instr[FN_HI:FN_LO];
  assign w_imm8  = i_instr[IMM_HI:IMM_LO];
  assign w_icode = {1'b0, w_op - 4'd1};

  // Decode by op class; NOP and illegal leave ALU controls at zero.
  always_comb begin
    o_rdest  = i_instr[RD_HI:RD_LO];
    o_rsrc   = i_instr[RS_HI:RS_LO];
    o_opcode = '0;
    o_imm    = '0;
    o_imm_s  = 1'b0;
    o_wr_en  = 1'b0;
    o_legal  = 1'b0;
    o_is_nop = 1'b0;
    unique case (1'b1)
      (w_op == OP_RTYPE): begin
        if (w_fn <= FN_MAX) begin
          o_legal  = 1'b1;
          o_opcode = {1'b0, w_fn};
          o_wr_en  = ({1'b0, w_fn} != ALU_CMP);
        end
      end
      (w_op != OP_RTYPE && w_op <= OP_IMAX): begin
        o_legal  = 1'b1;
        o_opcode = w_icode;
        o_imm_s  = 1'b1;
        o_wr_en  = (w_icode != ALU_CMP);
        if (imm_zext(w_icode))
          o_imm = {{(DATA_W-8){1'b0}}, w_imm8};
        else
          o_imm = {{(DATA_W-8){w_imm8[7]}}, w_imm8};
      end
      (w_op == OP_NOP): begin
        o_legal  = 1'b1;
        o_is_nop = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Instruction sequencer driving the RegFile_Alu datapath.
// ALU_SEQ_PERF_CNT_EN builds the retired-instruction counter.
module alu_instr_sequencer
  import alu_seq_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [INSTR_W-1:0]    InstrIn,
  input  logic                  InstrValid,
  output logic                  InstrReady,
  output logic [REG_ADDR_W-1:0] RdestRegLoc,
  output logic [REG_ADDR_W-1:0] RsrcRegLoc,
  output logic [4:0]            OpCode,
  output logic [DATA_W-1:0]     Imm,
  output logic                  Imm_s,
  output logic                  En,
  input  logic [FLAG_W-1:0]     Flags,
  output logic [FLAG_W-1:0]     FlagsReg,
  output logic                  Done,
  output logic                  IllegalInstr,
  output logic [15:0]           RetiredCnt
);

  state_t               r_state;
  state_t               w_next;
  logic [INSTR_W-1:0]   r_instr;
  logic [FLAG_W-1:0]    r_flags;
  logic                 w_accept;
  logic                 w_wr_en;
  logic                 w_legal;
  logic                 w_is_nop;

  alu_instr_decode u_dec (
    .i_instr  (r_instr),
    .o_rdest  (RdestRegLoc),
    .o_rsrc   (RsrcRegLoc),
    .o_opcode (OpCode),
    .o_imm    (Imm),
    .o_imm_s  (Imm_s),
    .o_wr_en  (w_wr_en),
    .o_legal  (w_legal),
    .o_is_nop (w_is_nop)
  );

  assign InstrReady   = (r_state == ST_IDLE) && !Rst;
  assign w_accept     = InstrValid && InstrReady;
  assign En           = (r_state == ST_EXEC) && w_wr_en && !Rst;
  assign Done         = (r_state == ST_DONE) && !Rst;
  assign IllegalInstr = Done && !w_legal;
  assign FlagsReg     = r_flags;

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state: one instruction walks IDLE -> EXEC -> DONE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture the instruction on accept; it drives decode until the next one.
  always_ff @(posedge Clk) begin
    if (Rst)           r_instr <= INSTR_NOP;
    else if (w_accept) r_instr <= InstrIn;
  end

  // Latch ALU flags at the end of EXEC for real ALU ops only.
  always_ff @(posedge Clk) begin
    if (Rst)
      r_flags <= '0;
    else if (r_state == ST_EXEC && w_legal && !w_is_nop)
      r_flags <= Flags;
  end

`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] r_cnt;

  // Count every retired instruction, wrapping naturally.
  always_ff @(posedge Clk) begin
    if (Rst)       r_cnt <= '0;
    else if (Done) r_cnt <= r_cnt + 16'd1;
  end

  assign RetiredCnt = r_cnt;
`else
  assign RetiredCnt = '0;
`endif

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed self-checking bench for alu_instr_sequencer.
// Hand-computed vectors; counter expectation follows ALU_SEQ_PERF_CNT_EN.
module tb_alu_instr_sequencer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] InstrIn;
  logic        InstrValid;
  logic        InstrReady;
  logic [3:0]  RdestRegLoc;
  logic [3:0]  RsrcRegLoc;
  logic [4:0]  OpCode;
  logic [15:0] Imm;
  logic        Imm_s;
  logic        En;
  logic [4:0]  Flags;
  logic [4:0]  FlagsReg;
  logic        Done;
  logic        IllegalInstr;
  logic [15:0] RetiredCnt;

`ifdef ALU_SEQ_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  alu_instr_sequencer dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .InstrIn      (InstrIn),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .RdestRegLoc  (RdestRegLoc),
    .RsrcRegLoc   (RsrcRegLoc),
    .OpCode       (OpCode),
    .Imm          (Imm),
    .Imm_s        (Imm_s),
    .En           (En),
    .Flags        (Flags),
    .FlagsReg     (FlagsReg),
    .Done         (Done),
    .IllegalInstr (IllegalInstr),
    .RetiredCnt   (RetiredCnt)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp();
    return CNT_ON ? 16'(exp_cnt) : 16'h0000;
  endfunction

  // Present one instruction from IDLE and check EXEC, DONE, return to IDLE.
  task automatic run(input string tag, input logic [15:0] ins,
                     input logic [4:0] fl, input logic en,
                     input logic [3:0] rd, input logic [3:0] rs,
                     input logic [4:0] oc, input logic [15:0] imm,
                     input logic ims, input logic ill,
                     input logic [4:0] fexp);
    InstrIn    = ins;
    InstrValid = 1'b1;
    Flags      = fl;
    #1;
    chk({tag, ".rdy"}, 16'(InstrReady), 16'd1);
    step();
    InstrValid = 1'b0;
    #1;
    chk({tag, ".en"},   16'(En), 16'(en));
    chk({tag, ".rd"},   16'(RdestRegLoc), 16'(rd));
    chk({tag, ".rs"},   16'(RsrcRegLoc), 16'(rs));
    chk({tag, ".op"},   16'(OpCode), 16'(oc));
    chk({tag, ".imm"},  Imm, imm);
    chk({tag, ".imms"}, 16'(Imm_s), 16'(ims));
    chk({tag, ".done0"}, 16'(Done), 16'd0);
    step();
    chk({tag, ".done"}, 16'(Done), 16'd1);
    chk({tag, ".ill"},  16'(IllegalInstr), 16'(ill));
    chk({tag, ".en1"},  16'(En), 16'd0);
    chk({tag, ".rdy1"}, 16'(InstrReady), 16'd0);
    chk({tag, ".flg"},  16'(FlagsReg), 16'(fexp));
    step();
    exp_cnt++;
    chk({tag, ".idle"}, 16'(InstrReady), 16'd1);
    chk({tag, ".cnt"},  RetiredCnt, cnt_exp());
  endtask

  initial begin
    Rst        = 1'b1;
    InstrIn    = 16'h0000;
    InstrValid = 1'b0;
    Flags      = 5'd0;
    step();
    chk("rst.rdy", 16'(InstrReady), 16'd0);
    chk("rst.en",  16'(En), 16'd0);
    step();
    Rst = 1'b0;
    #1;
    chk("init.rdy",  16'(InstrReady), 16'd1);
    chk("init.en",   16'(En), 16'd0);
    chk("init.flg",  16'(FlagsReg), 16'd0);
    chk("init.cnt",  RetiredCnt, 16'd0);
    chk("init.done", 16'(Done), 16'd0);
    chk("init.op",   16'(OpCode), 16'd0);

    run("addi", 16'h1305, 5'b00011, 1'b1, 4'h3, 4'h5,
        5'd0, 16'h0005, 1'b1, 1'b0, 5'b00011);
    run("subi", 16'h22FF, 5'b10000, 1'b1, 4'h2, 4'hF,
        5'd1, 16'hFFFF, 1'b1, 1'b0, 5'b10000);
    run("andi", 16'h44F0, 5'b00100, 1'b1, 4'h4, 4'h0,
        5'd3, 16'h00F0, 1'b1, 1'b0, 5'b00100);
    run("addineg", 16'h1A80, 5'b00001, 1'b1, 4'hA, 4'h0,
        5'd0, 16'hFF80, 1'b1, 1'b0, 5'b00001);
    run("arshi", 16'hA1FF, 5'b00010, 1'b1, 4'h1, 4'hF,
        5'd9, 16'h00FF, 1'b1, 1'b0, 5'b00010);
    run("cmp", 16'h0524, 5'b01010, 1'b0, 4'h5, 4'h4,
        5'd2, 16'h0000, 1'b0, 1'b0, 5'b01010);
    run("ill", 16'hB000, 5'b11111, 1'b0, 4'h0, 4'h0,
        5'd0, 16'h0000, 1'b0, 1'b1, 5'b01010);
    run("nop", 16'hF000, 5'b10101, 1'b0, 4'h0, 4'h0,
        5'd0, 16'h0000, 1'b0, 1'b0, 5'b01010);
    run("rand", 16'h0A3B, 5'b11000, 1'b1, 4'hA, 4'hB,
        5'd3, 16'h0000, 1'b0, 1'b0, 5'b11000);
    run("rill", 16'h0FA1, 5'b00111, 1'b0, 4'hF, 4'h1,
        5'd0, 16'h0000, 1'b0, 1'b1, 5'b11000);

    InstrIn    = 16'h1305;
    InstrValid = 1'b1;
    Flags      = 5'b11111;
    step();
    InstrValid = 1'b0;
    Rst        = 1'b1;
    #1;
    chk("rstx.en",   16'(En), 16'd0);
    chk("rstx.done", 16'(Done), 16'd0);
    step();
    Rst = 1'b0;
    #1;
    exp_cnt = 0;
    chk("rstx.done1", 16'(Done), 16'd0);
    chk("rstx.rdy",   16'(InstrReady), 16'd1);
    chk("rstx.flg",   16'(FlagsReg), 16'd0);
    chk("rstx.cnt",   RetiredCnt, 16'd0);

    InstrIn    = 16'h1101;
    InstrValid = 1'b1;
    Flags      = 5'd0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("thr.en",   16'(En),   16'((i % 3) == 0));
      chk("thr.done", 16'(Done), 16'((i % 3) == 1));
    end
    InstrValid = 1'b0;
    exp_cnt = 3;
    chk("thr.cnt", RetiredCnt, cnt_exp());
    step();
    chk("thr.idle", 16'(En), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
